mips_data_mem_responder: RTL and testbench
==========================================

# mips_data_mem_responder

Responder (slave) end of the single-cycle MIPS data-memory interface (CEN/WEN/OEN/A/D/Q). Holds a 128×32 word array and serves core loads with zero latency and stores at the clock edge. A load/run/dump state machine preloads memory through a valid/ready port while the core is held in reset, releases the core, then streams the final contents out for checking. Sits beside the core in the top-level and in the system bench.

## Interface
- ADDR_W, 7, word-address width (matches core A[6:0])
- DATA_W, 32, data width
- DEPTH, 128, words; equals 2**ADDR_W
- CNT_W, 16, access-counter width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- CEN  in  1  chip enable from core, active-low
- WEN  in  1  write enable from core, active-low
- OEN  in  1  output enable from core, active-low
- A  in  ADDR_W  word address from core
- D  in  DATA_W  store data from core
- Q  out  DATA_W  load data to core
- core_rst_n  out  1  core reset, low except in RUN
- ld_valid / ld_ready  in / out  1  loader handshake
- ld_addr, ld_data, ld_last  in  ADDR_W, DATA_W, 1  loader beat; ld_last marks final beat
- run_done  in  1  program finished, level sampled in RUN
- dmp_valid / dmp_ready  out / in  1  dump handshake
- dmp_addr, dmp_data  out  ADDR_W, DATA_W  dump beat
- rd_cnt, wr_cnt  out  CNT_W  core load/store counts, saturating
- err_conflict  out  1  sticky: CEN=0, WEN=0, OEN=0 seen in RUN

## Operation
- States: LOAD → RUN → DUMP → LOAD. Reset enters LOAD.
- Reset values: array all zero, Q=0, core_rst_n=0, ld_ready=1, dmp_valid=0, dmp_addr=0, rd_cnt=wr_cnt=0, err_conflict=0.
- LOAD: ld_ready=1. Each ld_valid&ld_ready writes mem[ld_addr]=ld_data at the edge. A beat with ld_last moves to RUN. Core pins are ignored.
- RUN: core_rst_n=1, ld_ready=0.
  - Write: CEN=0, WEN=0 → mem[A]=D at the edge; wr_cnt++.
  - Read: CEN=0, WEN=1, OEN=0 → Q=mem[A] combinationally; rd_cnt++ at the edge.
  - Conflict: CEN=0, WEN=0, OEN=0 → write still performed, Q=0, err_conflict set.
  - All other pin combinations → Q=0, no effect.
  - Counters saturate at 2**CNT_W−1.
  - Counters and err_conflict clear on entry to RUN.
  - run_done=1 at an edge moves to DUMP. A core write in that same cycle is still performed.
- DUMP: core_rst_n=0, Q=0, dmp_valid=1, dmp_data=mem[dmp_addr]. dmp_addr/data hold stable until dmp_ready.
  - Each handshake increments dmp_addr.
  - The handshake at DEPTH−1 wraps dmp_addr to 0, drops dmp_valid, and returns to LOAD.
  - Memory is retained across LOAD.
- Reset mid-operation (any state): all outputs and the array return to reset values immediately (asynchronously); state becomes LOAD.

## Timing
- Core read latency 0 cycles (combinational A→Q). Core write visible to a read on the next cycle.
- Loader: one beat per cycle; a beat written at edge n is readable by the core from its first RUN cycle.
- core_rst_n is decoded from the registered state. It goes high the cycle after the ld_last beat and low the cycle after run_done is sampled.
- Dump: one word per cycle with dmp_ready held high; 128 cycles minimum.
- ld_addr and A wrap naturally within ADDR_W; no out-of-range case exists.

## Structure
- Package mips_mem_pkg holds:
  - the state enum (LOAD, RUN, DUMP);
  - ADDR_W, DATA_W, DEPTH;
  - the access-decode constants: IDLE pins 1/1/0, READ pins 0/1/0, WRITE pins 0/0/1.
- Sub-module mips_mem_array: one write port, two combinational read ports (core, dump), async clear. The write port is muxed loader/core by state.

## Test plan
- Reset, then load mem[0]=0x1234_5678, mem[127]=0xDEAD_BEEF with ld_last on the second beat → core_rst_n=1 one cycle later.
- In RUN, read at A=0 → Q=0x1234_5678 in the same cycle; rd_cnt=1.
- In RUN, write D=0xCAFE_0001 at A=5, then read A=5 next cycle → Q=0xCAFE_0001; wr_cnt=1.
- Pins CEN=0, WEN=0, OEN=0 at A=9 with D=7 → Q=0, err_conflict=1, mem[9]=7 seen in dump.
- run_done → 128 dump beats with dmp_ready toggled 1/0 each cycle. Data stays stable while dmp_ready=0; addr 127 shows 0xDEAD_BEEF; state then returns to LOAD, ld_ready=1.
- Assert rst_n low mid-DUMP at dmp_addr=40 → dmp_valid=0 and core_rst_n=0 immediately; mem reads back zero after the next load/dump.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS data-memory responder.
// The core pin encodings are written as {CEN, WEN, OEN}.
package mips_mem_pkg;

   localparam int ADDR_W = 7;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 2 ** ADDR_W;
   localparam int CNT_W  = 16;

   typedef enum logic [1:0] {
      LOAD,
      RUN,
      DUMP
   } state_e;

   localparam logic [2:0] PINS_IDLE     = 3'b110;
   localparam logic [2:0] PINS_READ     = 3'b010;
   localparam logic [2:0] PINS_WRITE    = 3'b001;
   localparam logic [2:0] PINS_CONFLICT = 3'b000;

   // A store happens whenever CEN and WEN are both low, whatever OEN does.
   function automatic logic is_core_write(input logic [2:0] pins);
      return pins[2:1] == PINS_WRITE[2:1];
   endfunction

endpackage

// File: rtl/mips_mem_array.sv
// DEPTH x DATA_W word array: one synchronous write port, two combinational
// read ports (core and dump), asynchronously cleared by rst_n.
module mips_mem_array
   import mips_mem_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] core_addr,
   output logic [DATA_W-1:0] core_data,
   input  logic [ADDR_W-1:0] dump_addr,
   output logic [DATA_W-1:0] dump_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   // NOTE: the array is part of the reset domain on purpose; every word must
   // read zero after rst_n, so this is a register file, not an inferred RAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign core_data = mem[core_addr];
   assign dump_data = mem[dump_addr];

endmodule

// File: rtl/mips_data_mem_responder.sv
// Responder end of the single-cycle MIPS data-memory interface, with a
// load/run/dump sequencer that preloads memory, runs the core, and dumps.
module mips_data_mem_responder
   import mips_mem_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              CEN,
   input  logic              WEN,
   input  logic              OEN,
   input  logic [ADDR_W-1:0] A,
   input  logic [DATA_W-1:0] D,
   output logic [DATA_W-1:0] Q,
   output logic              core_rst_n,
   input  logic              ld_valid,
   output logic              ld_ready,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   input  logic              run_done,
   output logic              dmp_valid,
   input  logic              dmp_ready,
   output logic [ADDR_W-1:0] dmp_addr,
   output logic [DATA_W-1:0] dmp_data,
   output logic [CNT_W-1:0]  rd_cnt,
   output logic [CNT_W-1:0]  wr_cnt,
   output logic              err_conflict
);

   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
   localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(DEPTH - 1);

   state_e            state, state_nxt;
   logic [2:0]        pins;
   logic              core_wr, core_rd, core_conflict;
   logic              ld_fire, dmp_fire, run_entry;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] core_data;

   assign pins          = {CEN, WEN, OEN};
   assign core_wr       = (state == RUN) && is_core_write(pins);
   assign core_rd       = (state == RUN) && (pins == PINS_READ);
   assign core_conflict = (state == RUN) && (pins == PINS_CONFLICT);
   assign ld_fire       = (state == LOAD) && ld_valid;
   assign dmp_fire      = (state == DUMP) && dmp_ready;
   assign run_entry     = ld_fire && ld_last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= LOAD;
      else        state <= state_nxt;
   end

   // NOTE: every always_comb output gets a default before the case so that
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_nxt = state;
      unique case (state)
         LOAD:    if (run_entry) state_nxt = RUN;
         RUN:     if (run_done) state_nxt = DUMP;
         DUMP:    if (dmp_fire && dmp_addr == LAST_ADR) state_nxt = LOAD;
         default: state_nxt = LOAD;
      endcase
   end

   // Single write port: the loader owns it in LOAD, the core in RUN.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = A;
      mem_wdata = D;
      if (state == LOAD) begin
         mem_we    = ld_fire;
         mem_waddr = ld_addr;
         mem_wdata = ld_data;
      end else if (state == RUN) begin
         mem_we = core_wr;
      end
   end

   mips_mem_array u_array (
      .clk       (clk),
      .rst_n     (rst_n),
      .we        (mem_we),
      .waddr     (mem_waddr),
      .wdata     (mem_wdata),
      .core_addr (A),
      .core_data (core_data),
      .dump_addr (dmp_addr),
      .dump_data (dmp_data)
   );

   // Statistics restart on each entry to RUN and saturate rather than wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_cnt       <= '0;
         wr_cnt       <= '0;
         err_conflict <= 1'b0;
      end else if (run_entry) begin
         rd_cnt       <= '0;
         wr_cnt       <= '0;
         err_conflict <= 1'b0;
      end else begin
         if (core_rd && rd_cnt != CNT_MAX) rd_cnt <= rd_cnt + 1'b1;
         if (core_wr && wr_cnt != CNT_MAX) wr_cnt <= wr_cnt + 1'b1;
         if (core_conflict)                err_conflict <= 1'b1;
      end
   end

   // The last handshake wraps the pointer back to 0 for the next dump.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        dmp_addr <= '0;
      else if (dmp_fire) dmp_addr <= dmp_addr + 1'b1;
   end

   assign Q          = core_rd ? core_data : '0;
   assign core_rst_n = (state == RUN);
   assign ld_ready   = (state == LOAD);
   assign dmp_valid  = (state == DUMP);

endmodule

// File: tb/tb_mips_data_mem_responder.sv
// Scoreboard bench for mips_data_mem_responder: stimulus queues expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mips_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        CEN, WEN, OEN;
   logic [6:0]  A;
   logic [31:0] D;
   logic [31:0] Q;
   logic        core_rst_n;
   logic        ld_valid, ld_ready, ld_last;
   logic [6:0]  ld_addr;
   logic [31:0] ld_data;
   logic        run_done;
   logic        dmp_valid, dmp_ready;
   logic [6:0]  dmp_addr;
   logic [31:0] dmp_data;
   logic [15:0] rd_cnt, wr_cnt;
   logic        err_conflict;

   always #5 clk = ~clk;

   mips_data_mem_responder dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .CEN          (CEN),
      .WEN          (WEN),
      .OEN          (OEN),
      .A            (A),
      .D            (D),
      .Q            (Q),
      .core_rst_n   (core_rst_n),
      .ld_valid     (ld_valid),
      .ld_ready     (ld_ready),
      .ld_addr      (ld_addr),
      .ld_data      (ld_data),
      .ld_last      (ld_last),
      .run_done     (run_done),
      .dmp_valid    (dmp_valid),
      .dmp_ready    (dmp_ready),
      .dmp_addr     (dmp_addr),
      .dmp_data     (dmp_data),
      .rd_cnt       (rd_cnt),
      .wr_cnt       (wr_cnt),
      .err_conflict (err_conflict)
   );

   typedef enum {S_Q, S_CORE_RST, S_LD_READY, S_DMP_VALID, S_DMP_ADDR,
                 S_RD_CNT, S_WR_CNT, S_ERR} sel_e;
   typedef struct {sel_e sel; logic [31:0] val; string name;} chk_t;
   typedef struct {logic [6:0] addr; logic [31:0] data;} beat_t;

   chk_t        stat_q[$];
   beat_t       dump_q[$];
   logic [31:0] model [128];
   int          checks = 0;
   int          passed = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   function automatic logic [31:0] observe(input sel_e s);
      case (s)
         S_Q:         return Q;
         S_CORE_RST:  return {31'b0, core_rst_n};
         S_LD_READY:  return {31'b0, ld_ready};
         S_DMP_VALID: return {31'b0, dmp_valid};
         S_DMP_ADDR:  return {25'b0, dmp_addr};
         S_RD_CNT:    return {16'b0, rd_cnt};
         S_WR_CNT:    return {16'b0, wr_cnt};
         default:     return {31'b0, err_conflict};
      endcase
   endfunction

   task automatic expect_now(input sel_e s, input logic [31:0] v, input string n);
      stat_q.push_back('{s, v, n});
   endtask

   // Monitor: drains status expectations and scores dump beats on the falling edge.
   always @(negedge clk) begin
      chk_t  c;
      beat_t b;
      while (stat_q.size() > 0) begin
         c = stat_q.pop_front();
         check(c.name, observe(c.sel), c.val);
      end
      if (dmp_valid) begin
         if (dump_q.size() == 0) begin
            check("dump_unexpected_valid", {31'b0, dmp_valid}, 32'd0);
         end else begin
            b = dump_q[0];
            check($sformatf("dump_addr[%0d]", b.addr), {25'b0, dmp_addr}, {25'b0, b.addr});
            check($sformatf("dump_data[%0d]", b.addr), dmp_data, b.data);
            if (dmp_ready) void'(dump_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pins(input logic c, input logic w, input logic o,
                           input logic [6:0] a, input logic [31:0] d);
      CEN = c; WEN = w; OEN = o; A = a; D = d;
   endtask

   task automatic push_dump();
      for (int i = 0; i < 128; i++) dump_q.push_back('{7'(i), model[i]});
   endtask

   task automatic run_dump(input bit toggle, input int budget);
      int n = 0;
      dmp_ready = 1'b1;
      while (dump_q.size() > 0 && n < budget) begin
         step();
         n++;
         if (toggle) dmp_ready = ~dmp_ready;
      end
      if (dump_q.size() > 0) begin
         check("dump_timeout_remaining", dump_q.size(), 32'd0);
         dump_q.delete();
      end
      dmp_ready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
      $fatal(1);
   end

   initial begin
      int n;
      rst_n = 1'b0;
      set_pins(1'b1, 1'b1, 1'b1, 7'd0, 32'd0);
      ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_last = 1'b0;
      run_done = 1'b0; dmp_ready = 1'b0;
      for (int i = 0; i < 128; i++) model[i] = 32'd0;

      // Reset state
      #2;
      expect_now(S_Q, 32'd0, "rst_q");
      expect_now(S_CORE_RST, 32'd0, "rst_core_rst_n");
      expect_now(S_LD_READY, 32'd1, "rst_ld_ready");
      expect_now(S_DMP_VALID, 32'd0, "rst_dmp_valid");
      expect_now(S_DMP_ADDR, 32'd0, "rst_dmp_addr");
      expect_now(S_RD_CNT, 32'd0, "rst_rd_cnt");
      expect_now(S_WR_CNT, 32'd0, "rst_wr_cnt");
      expect_now(S_ERR, 32'd0, "rst_err");
      step();
      rst_n = 1'b1;
      step();

      // Load two beats; core write pins are ignored while loading
      ld_valid = 1'b1; ld_addr = 7'd0; ld_data = 32'h1234_5678; ld_last = 1'b0;
      model[0] = 32'h1234_5678;
      set_pins(1'b0, 1'b0, 1'b1, 7'd50, 32'h0000_0BAD);
      expect_now(S_LD_READY, 32'd1, "load_ld_ready");
      step();
      ld_addr = 7'd127; ld_data = 32'hDEAD_BEEF; ld_last = 1'b1;
      model[127] = 32'hDEAD_BEEF;
      expect_now(S_CORE_RST, 32'd0, "load_last_core_rst_n");
      step();
      ld_valid = 1'b0; ld_last = 1'b0;

      // RUN: read A=0 combinationally
      set_pins(1'b0, 1'b1, 1'b0, 7'd0, 32'd0);
      expect_now(S_CORE_RST, 32'd1, "run_core_rst_n");
      expect_now(S_LD_READY, 32'd0, "run_ld_ready");
      expect_now(S_RD_CNT, 32'd0, "run_rd_cnt0");
      expect_now(S_Q, 32'h1234_5678, "read_a0");
      step();
      set_pins(1'b0, 1'b0, 1'b1, 7'd5, 32'hCAFE_0001);
      model[5] = 32'hCAFE_0001;
      expect_now(S_Q, 32'd0, "write_q");
      expect_now(S_RD_CNT, 32'd1, "rd_cnt1");
      step();
      set_pins(1'b0, 1'b1, 1'b0, 7'd5, 32'd0);
      expect_now(S_Q, 32'hCAFE_0001, "read_back_a5");
      expect_now(S_WR_CNT, 32'd1, "wr_cnt1");
      step();
      set_pins(1'b0, 1'b1, 1'b1, 7'd5, 32'd0);
      expect_now(S_Q, 32'd0, "oen_high_q");
      expect_now(S_RD_CNT, 32'd2, "rd_cnt2");
      step();
      set_pins(1'b0, 1'b0, 1'b0, 7'd9, 32'd7);
      model[9] = 32'd7;
      expect_now(S_Q, 32'd0, "conflict_q");
      expect_now(S_ERR, 32'd0, "err_before");
      expect_now(S_RD_CNT, 32'd2, "rd_cnt_oen_high");
      step();
      set_pins(1'b1, 1'b1, 1'b0, 7'd0, 32'd0);
      expect_now(S_Q, 32'd0, "idle_q");
      expect_now(S_ERR, 32'd1, "err_set");
      expect_now(S_WR_CNT, 32'd2, "wr_cnt2");
      expect_now(S_RD_CNT, 32'd2, "rd_cnt_idle");
      step();

      // run_done with a simultaneous core write
      run_done = 1'b1;
      set_pins(1'b0, 1'b0, 1'b1, 7'd10, 32'hA5A5_0010);
      model[10] = 32'hA5A5_0010;
      expect_now(S_CORE_RST, 32'd1, "run_done_cycle_core_rst_n");
      push_dump();
      dmp_ready = 1'b1;
      step();
      run_done = 1'b0;
      set_pins(1'b0, 1'b1, 1'b0, 7'd0, 32'd0);
      expect_now(S_Q, 32'd0, "dump_q_zero");
      expect_now(S_CORE_RST, 32'd0, "dump_core_rst_n");
      expect_now(S_DMP_VALID, 32'd1, "dump_valid");
      expect_now(S_LD_READY, 32'd0, "dump_ld_ready");
      run_dump(1'b1, 400);
      set_pins(1'b1, 1'b1, 1'b1, 7'd0, 32'd0);
      expect_now(S_LD_READY, 32'd1, "post_dump_ld_ready");
      expect_now(S_DMP_VALID, 32'd0, "post_dump_valid");
      expect_now(S_DMP_ADDR, 32'd0, "post_dump_addr_wrap");
      expect_now(S_CORE_RST, 32'd0, "post_dump_core_rst_n");
      step();

      // Second pass: counters clear on RUN entry, then reset mid-dump
      ld_valid = 1'b1; ld_addr = 7'd20; ld_data = 32'h2020_2020; ld_last = 1'b1;
      model[20] = 32'h2020_2020;
      step();
      ld_valid = 1'b0; ld_last = 1'b0;
      expect_now(S_RD_CNT, 32'd0, "rerun_rd_cnt_clear");
      expect_now(S_WR_CNT, 32'd0, "rerun_wr_cnt_clear");
      expect_now(S_ERR, 32'd0, "rerun_err_clear");
      run_done = 1'b1;
      push_dump();
      dmp_ready = 1'b1;
      step();
      run_done = 1'b0;
      n = 0;
      while (dmp_addr != 7'd40 && n < 300) begin
         step();
         n++;
         dmp_ready = ~dmp_ready;
      end
      if (dmp_addr != 7'd40) check("wait_addr40_timeout", {25'b0, dmp_addr}, 32'd40);
      rst_n = 1'b0;
      #1;
      dump_q.delete();
      expect_now(S_DMP_VALID, 32'd0, "midrst_dmp_valid");
      expect_now(S_CORE_RST, 32'd0, "midrst_core_rst_n");
      expect_now(S_LD_READY, 32'd1, "midrst_ld_ready");
      expect_now(S_DMP_ADDR, 32'd0, "midrst_dmp_addr");
      dmp_ready = 1'b0;
      for (int i = 0; i < 128; i++) model[i] = 32'd0;
      step();
      rst_n = 1'b1;
      step();

      // Third pass: memory must have been cleared by reset
      ld_valid = 1'b1; ld_addr = 7'd1; ld_data = 32'h0000_0011; ld_last = 1'b1;
      model[1] = 32'h0000_0011;
      step();
      ld_valid = 1'b0; ld_last = 1'b0;
      run_done = 1'b1;
      push_dump();
      step();
      run_done = 1'b0;
      run_dump(1'b0, 200);
      expect_now(S_LD_READY, 32'd1, "final_ld_ready");
      @(negedge clk);
      #1;
      if (stat_q.size() > 0) check("status_queue_leftover", stat_q.size(), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
